// File: rtl/ball_game_ctrl.sv
// ball_game_ctrl: per-frame ball motion, player-hit detection, score keeping and IDLE/PLAY/OVER control.
// Optional macro SPEEDUP_EN: a hit that lands the score on a nonzero multiple of 10 raises |vy| by 1, capped at MAX_SPEED.
module ball_game_ctrl #(
  parameter int unsigned H_RES           = 640,
  parameter int unsigned V_RES           = 480,
  parameter int unsigned BALL_SIZE       = 20,
  parameter int unsigned INIT_X          = 310,
  parameter int unsigned INIT_Y          = 40,
  parameter int          INIT_VX         = 2,
  parameter int          INIT_VY         = 3,
  parameter int unsigned HIT_THRESH      = 16,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned MAX_SPEED       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       de,
  input  logic       is_hit_area,
  input  logic       hand_detect,
  input  logic       start_btn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] score,
  output logic       game_over,
  output logic       is_idle
);

  localparam int unsigned X_MAX = H_RES - BALL_SIZE;
  localparam int unsigned Y_MAX = V_RES - BALL_SIZE;
  localparam int unsigned CW    = $clog2(COOLDOWN_FRAMES + 1);
`ifdef SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_e;

  state_e             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic signed [10:0] vx_q, vx_d, vy_q, vy_d;
  logic [7:0]         score_q, score_d, hit_cnt_q, hit_cnt_d;
  logic [CW-1:0]      cool_q, cool_d;
  logic               start_q, game_over_q, game_over_d, is_idle_q, is_idle_d;
  logic               start_rise, match, hit, floor_hit;
  logic [7:0]         score_inc;
  logic signed [10:0] vy_hit, nx, ny;

  assign start_rise = start_btn & ~start_q;
  assign match      = de & is_hit_area & hand_detect;

  // Frame-update arithmetic: hit decision, post-hit velocity, candidate position
  always_comb begin
    hit       = (hit_cnt_q >= 8'(HIT_THRESH)) && (vy_q > 11'sd0) && (cool_q == '0);
    score_inc = (score_q >= 8'd99) ? 8'd99 : score_q + 8'd1;
    vy_hit    = vy_q;
    if (hit) begin
      vy_hit = -vy_q;
      if (SPEEDUP && (score_inc % 8'd10 == 8'd0) && (vy_q < $signed(11'(MAX_SPEED))))
        vy_hit = -(vy_q + 11'sd1);
    end
    nx        = $signed({1'b0, x_q}) + vx_q;
    ny        = $signed({1'b0, y_q}) + vy_hit;
    floor_hit = (ny >= $signed(11'(Y_MAX)));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_rise) state_d = S_PLAY;
      S_PLAY:  if (frame_tick && floor_hit) state_d = S_OVER;
      S_OVER:  if (start_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and flag next values
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    score_d     = score_q;
    hit_cnt_d   = hit_cnt_q;
    cool_d      = cool_q;
    game_over_d = (state_d == S_OVER);
    is_idle_d   = (state_d == S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        x_d       = 10'(INIT_X);
        y_d       = 10'(INIT_Y);
        vx_d      = 11'(INIT_VX);
        vy_d      = 11'(INIT_VY);
        hit_cnt_d = '0;
      end
      S_PLAY: begin
        if (frame_tick) begin
          hit_cnt_d = '0;
          if (hit) begin
            score_d = score_inc;
            cool_d  = CW'(COOLDOWN_FRAMES);
          end else if (cool_q != '0) begin
            cool_d = cool_q - CW'(1);
          end
          vy_d = vy_hit;
          if (nx[10]) begin
            x_d  = '0;
            vx_d = -vx_q;
          end else if (nx > $signed(11'(X_MAX))) begin
            x_d  = 10'(X_MAX);
            vx_d = -vx_q;
          end else begin
            x_d = nx[9:0];
          end
          if (ny[10]) begin
            y_d  = '0;
            vy_d = -vy_hit;
          end else if (floor_hit) begin
            y_d = 10'(Y_MAX);
          end else begin
            y_d = ny[9:0];
          end
        end else if (match && (hit_cnt_q != 8'hFF)) begin
          hit_cnt_d = hit_cnt_q + 8'd1;
        end
      end
      S_OVER: begin
        if (start_rise) begin
          x_d       = 10'(INIT_X);
          y_d       = 10'(INIT_Y);
          vx_d      = 11'(INIT_VX);
          vy_d      = 11'(INIT_VY);
          score_d   = '0;
          cool_d    = '0;
          hit_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= 10'(INIT_X);
      y_q         <= 10'(INIT_Y);
      vx_q        <= 11'(INIT_VX);
      vy_q        <= 11'(INIT_VY);
      score_q     <= '0;
      hit_cnt_q   <= '0;
      cool_q      <= '0;
      start_q     <= 1'b0;
      game_over_q <= 1'b0;
      is_idle_q   <= 1'b1;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      score_q     <= score_d;
      hit_cnt_q   <= hit_cnt_d;
      cool_q      <= cool_d;
      start_q     <= start_btn;
      game_over_q <= game_over_d;
      is_idle_q   <= is_idle_d;
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign score     = score_q;
  assign game_over = game_over_q;
  assign is_idle   = is_idle_q;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Self-checking bench for ball_game_ctrl: directed vector table, directed game sequences and
// randomized play, all checked against a frame-level behavioural model of the game rules.
module tb_ball_game_ctrl;

  localparam int X_MAX  = 620;
  localparam int Y_MAX  = 460;
  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, frame_tick = 1'b0, de = 1'b0;
  logic       is_hit_area = 1'b0, hand_detect = 1'b0, start_btn = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic [7:0] score;
  logic       game_over, is_idle;

  always #5 clk = ~clk;

  ball_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .de          (de),
    .is_hit_area (is_hit_area),
    .hand_detect (hand_detect),
    .start_btn   (start_btn),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .score       (score),
    .game_over   (game_over),
    .is_idle     (is_idle)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the game, updated once per clock
  int mx, my, mvx, mvy, mscore, mcnt, mcool, mmode;
  bit mstart;

  task automatic model_restart();
    mx = 310; my = 40; mvx = 2; mvy = 3;
    mscore = 0; mcnt = 0; mcool = 0;
  endtask

  task automatic model_frame();
    bit hit;
    int nx, ny;
    hit = (mcnt >= 16) && (mvy > 0) && (mcool == 0);
    if (hit) begin
      mscore = (mscore + 1 > 99) ? 99 : mscore + 1;
      mvy = -mvy;
`ifdef SPEEDUP_EN
      if ((mscore % 10 == 0) && (-mvy < 7)) mvy = mvy - 1;
`endif
      mcool = 8;
    end else if (mcool > 0) begin
      mcool--;
    end
    nx = mx + mvx;
    if (nx < 0) begin mx = 0; mvx = -mvx; end
    else if (nx > X_MAX) begin mx = X_MAX; mvx = -mvx; end
    else mx = nx;
    ny = my + mvy;
    if (ny < 0) begin my = 0; mvy = -mvy; end
    else if (ny >= Y_MAX) begin my = Y_MAX; mmode = M_OVER; end
    else my = ny;
    mcnt = 0;
  endtask

  task automatic model_clock(input bit r, input bit ft, input bit d, input bit ha, input bit hd, input bit sb);
    bit rise;
    if (r) begin
      model_restart();
      mmode  = M_IDLE;
      mstart = 1'b0;
      return;
    end
    rise   = sb && !mstart;
    mstart = sb;
    case (mmode)
      M_IDLE: if (rise) mmode = M_PLAY;
      M_PLAY: begin
        if (ft) model_frame();
        else if (d && ha && hd && mcnt < 255) mcnt++;
      end
      default: if (rise) begin model_restart(); mmode = M_IDLE; end
    endcase
  endtask

  // One clock: drive, model update, compare all outputs against the model
  task automatic cyc(input bit r, input bit ft, input bit d, input bit ha, input bit hd, input bit sb);
    logic [29:0] exp_v, act_v;
    reset = r; frame_tick = ft; de = d; is_hit_area = ha; hand_detect = hd; start_btn = sb;
    @(posedge clk);
    model_clock(r, ft, d, ha, hd, sb);
    #1;
    exp_v = {10'(mx), 10'(my), 8'(mscore), (mmode == M_OVER), (mmode == M_IDLE)};
    act_v = {ball_x, ball_y, score, game_over, is_idle};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t got x=%0d y=%0d sc=%0d go=%0b idle=%0b exp x=%0d y=%0d sc=%0d go=%0b idle=%0b",
               $time, ball_x, ball_y, score, game_over, is_idle, mx, my, mscore, mmode == M_OVER, mmode == M_IDLE);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pixels(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // Frame that feeds a full hit's worth of pixels whenever the ball is falling
  task automatic play_frame();
    if (mvy > 0) pixels(16);
    tick();
  endtask

  typedef struct {
    bit r, ft, d, ha, hd, sb;
    int ex, ey, esc;
    bit ego, eidle;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit ft, input bit d, input bit ha, input bit hd, input bit sb,
                     input int ex, input int ey, input int esc, input bit ego, input bit eidle);
    vec_t v;
    v.r = r; v.ft = ft; v.d = d; v.ha = ha; v.hd = hd; v.sb = sb;
    v.ex = ex; v.ey = ey; v.esc = esc; v.ego = ego; v.eidle = eidle;
    tbl.push_back(v);
  endtask

  initial begin
    int xs, n;
    bit sbl, found;

    //  r ft d ha hd sb   x    y  sc go idle
    add(1, 0, 0, 0, 0, 0, 310, 40, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 310, 40, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 310, 40, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 310, 40, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 310, 40, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 312, 43, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 312, 43, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 314, 46, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 314, 46, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 316, 49, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 316, 49, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 318, 52, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].ft, tbl[i].d, tbl[i].ha, tbl[i].hd, tbl[i].sb);
      checks++;
      if ({ball_x, ball_y, score, game_over, is_idle} !==
          {10'(tbl[i].ex), 10'(tbl[i].ey), 8'(tbl[i].esc), tbl[i].ego, tbl[i].eidle}) begin
        errors++;
        $display("FAIL vec%0d got x=%0d y=%0d sc=%0d go=%0b idle=%0b expected x=%0d y=%0d sc=%0d go=%0b idle=%0b",
                 i, ball_x, ball_y, score, game_over, is_idle,
                 tbl[i].ex, tbl[i].ey, tbl[i].esc, tbl[i].ego, tbl[i].eidle);
      end
    end

    // 15 counted pixels plus one coinciding with the tick: below threshold, no hit
    pixels(15);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("thresh_minus1_score", score, 0);
    chk("thresh_minus1_y", ball_y, 55);
    // Exactly the threshold: hit, vy flips upward
    pixels(16);
    tick();
    chk("hit_score", score, 1);
    chk("hit_y", ball_y, 52);
    // Next frame is in cooldown (and rising): no further score
    pixels(20);
    tick();
    chk("cooldown_score", score, 1);
    chk("cooldown_y", ball_y, 49);

    // No hits until the floor
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick();
      found = (mmode == M_OVER);
    end
    chk("floor_reached", 32'(found), 1);
    chk("over_flag", game_over, 1);
    chk("over_y", ball_y, Y_MAX);
    xs = mx;
    repeat (5) tick();
    chk("frozen_x", ball_x, xs);
    chk("frozen_y", ball_y, Y_MAX);
    chk("frozen_score", score, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_idle", is_idle, 1);
    chk("restart_x", ball_x, 310);
    chk("restart_y", ball_y, 40);
    chk("restart_score", score, 0);
    chk("restart_over", game_over, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Score saturation at 99
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5000 && mscore < 99 && mmode == M_PLAY; k++) play_frame();
    chk("score_99", score, 99);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      found = (mvy > 0) && (mcool == 0);
      if (!found) tick();
    end
    chk("hit_ready", 32'(found), 1);
    pixels(20);
    tick();
    chk("score_sat", score, 99);
    chk("sat_playing", game_over, 0);

    // Right wall: 620 moving right, clamp once, then move left
    found = 1'b0;
    for (int k = 0; k < 2000 && !found && mmode == M_PLAY; k++) begin
      found = (mx == X_MAX) && (mvx > 0);
      if (!found) play_frame();
    end
    chk("wall_reached", 32'(found), 1);
    tick();
    chk("wall_clamp", ball_x, 620);
    tick();
    chk("wall_bounce", ball_x, 618);

    // Randomized play
    sbl = 1'b0;
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 199) == 0) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sbl);
      if ($urandom_range(0, 9) == 0) sbl = ~sbl;
      n = $urandom_range(0, 40);
      repeat (n) cyc(1'b0, 1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) != 0), sbl);
      cyc(1'b0, 1'b1, ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0),
          ($urandom_range(0, 1) != 0), sbl);
    end

    // Reset mid-PLAY wins over a simultaneous start edge
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pixels(16);
    tick();
    tick();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_x", ball_x, 310);
    chk("rst_y", ball_y, 40);
    chk("rst_score", score, 0);
    chk("rst_over", game_over, 0);
    chk("rst_idle", is_idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
